shift_fifo_ctrl: RTL and testbench
==================================

// Module: shift_fifo_ctrl
// PURPOSE
//  Sequences one PIO state machine's OSR and ISR shifters against its TX/RX FIFOs.
//  Executes OUT/IN/PULL/PUSH micro-ops from the instruction decoder.
//  Tracks OSR/ISR shift counts, performs autopull/autopush at configured thresholds.
//  Stalls the state machine when a FIFO blocks progress.
// PARAMETERS
//  OSR_RST_CNT  32  osr_count after reset (32 = OSR empty, first OUT autopulls)
//  CNT_W        6   count width, holds 0..32
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high
//  penable      in   1   clock-divider enable; state changes only when 1
//  op_valid     in   1   micro-op present, held until op_done
//  op_type      in   2   0=OUT 1=IN 2=PULL 3=PUSH
//  op_bits      in   5   OUT/IN bit count, 0 encodes 32
//  op_block     in   1   PULL/PUSH block flag
//  autopull     in   1   autopull enable
//  autopush     in   1   autopush enable
//  pull_thresh  in   5   autopull threshold, 0 encodes 32
//  push_thresh  in   5   autopush threshold, 0 encodes 32
//  tx_empty     in   1   TX FIFO empty
//  rx_full      in   1   RX FIFO full
//  tx_pop       out  1   pop TX FIFO (data goes straight to OSR din)
//  rx_push      out  1   push ISR contents into RX FIFO
//  osr_load     out  1   OSR set strobe
//  osr_shift    out  1   OSR shift strobe
//  isr_shift    out  1   ISR shift strobe
//  isr_clear    out  1   clear ISR
//  shift_amt    out  6   bits to shift, 1..32
//  osr_count    out  6   bits shifted out since last load, 0..32
//  isr_count    out  6   bits shifted in since last clear, 0..32
//  stall        out  1   op cannot complete this cycle
//  op_done      out  1   one-cycle pulse, op retired
// BEHAVIOUR
//  Reset (state, outputs):
//    - FSM state IDLE; osr_count=OSR_RST_CNT; isr_count=0.
//    - All strobes, stall and op_done = 0.
//  Reset mid-op aborts the op with no FIFO side effects.
//  Strobes and op_done are combinational from the state; asserted only when penable=1.
//  stall is 0 when penable=0. Counts saturate at 32: cnt' = min(cnt+n, 32).
//  FSM states: IDLE, OUT_GO, IN_PUSH.
//  IDLE, OUT:
//    - autopull && osr_count>=pull_thresh && tx_empty -> stall.
//    - autopull && osr_count>=pull_thresh && !tx_empty -> tx_pop+osr_load, osr_count<=0,
//      stall, go OUT_GO.
//    - Otherwise osr_shift, shift_amt=op_bits, osr_count+=op_bits, op_done.
//  OUT_GO: osr_shift, osr_count+=op_bits, op_done, go IDLE. Total latency 2 cycles.
//  IDLE, IN:
//    - isr_shift, isr_count+=op_bits.
//    - If autopush && new count>=push_thresh: stall, go IN_PUSH; else op_done.
//  IN_PUSH:
//    - rx_full -> stall, hold.
//    - Else rx_push+isr_clear, isr_count<=0, op_done, go IDLE.
//  IDLE, PULL:
//    - Not empty: tx_pop+osr_load, osr_count<=0, op_done.
//    - Empty && op_block: stall.
//    - Empty && !op_block: op_done, OSR untouched.
//  IDLE, PUSH:
//    - Not full: rx_push+isr_clear, isr_count<=0, op_done.
//    - Full && op_block: stall.
//    - Full && !op_block: isr_clear, isr_count<=0, op_done (data dropped).
//  Background autopull in IDLE with no op_valid:
//    - Condition: autopull && osr_count>=pull_thresh && !tx_empty.
//    - Action: tx_pop+osr_load, osr_count<=0, no op_done.
//  tx_pop never when tx_empty; rx_push never when rx_full.
//  tx_pop/rx_push at most one each per cycle.
//  op_valid dropping mid-op is illegal (controller FSM continues to completion).
// TESTING
//  1. reset, autopull=1, pull_thresh=0, tx has 1 word, OUT 8
//     -> cycle1 tx_pop+osr_load+stall; cycle2 osr_shift amt=8, op_done, osr_count=8.
//  2. OUT 8 x4 after load, pull_thresh=0, tx_empty
//     -> osr_count 8,16,24,32; 5th OUT stalls until tx_empty=0, then pop and shift.
//  3. autopush=1, push_thresh=16, IN 8 twice, rx_full=1 for 3 cycles
//     -> isr_count 8,16; stall 3 cycles; then rx_push+isr_clear, isr_count=0, op_done.
//  4. PULL noblock with tx_empty -> op_done same cycle, no tx_pop, osr_count unchanged.
//     PUSH noblock with rx_full -> isr_clear, no rx_push.
//  5. penable toggling 1,0,1 during OUT refill
//     -> no strobes, stall or state change on penable=0 cycles; sequence completes identically.
//  6. reset asserted in IN_PUSH while rx_full -> next cycle IDLE, isr_count=0, no rx_push ever.

Source files
------------

// File: rtl/shift_fifo_ctrl.sv
// Sequences one PIO state machine's OSR/ISR shifters against the TX/RX FIFOs:
// executes OUT/IN/PULL/PUSH micro-ops, tracks shift counts, and handles autopull/autopush.
module shift_fifo_ctrl #(
    parameter int OSR_RST_CNT = 32,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             penable,
    input  logic             op_valid,
    input  logic [1:0]       op_type,
    input  logic [4:0]       op_bits,
    input  logic             op_block,
    input  logic             autopull,
    input  logic             autopush,
    input  logic [4:0]       pull_thresh,
    input  logic [4:0]       push_thresh,
    input  logic             tx_empty,
    input  logic             rx_full,
    output logic             tx_pop,
    output logic             rx_push,
    output logic             osr_load,
    output logic             osr_shift,
    output logic             isr_shift,
    output logic             isr_clear,
    output logic [CNT_W-1:0] shift_amt,
    output logic [CNT_W-1:0] osr_count,
    output logic [CNT_W-1:0] isr_count,
    output logic             stall,
    output logic             op_done
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(32);
    localparam logic [1:0] OP_OUT  = 2'd0;
    localparam logic [1:0] OP_IN   = 2'd1;
    localparam logic [1:0] OP_PULL = 2'd2;
    localparam logic [1:0] OP_PUSH = 2'd3;

    typedef enum logic [1:0] {IDLE, OUT_GO, IN_PUSH} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] osr_count_nxt, isr_count_nxt;
    logic [CNT_W-1:0] bits_n, pull_thr, push_thr, isr_sum;
    logic             active, pull_due;

    // Shift counts never exceed a full 32-bit register.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, FULL_CNT})
            return FULL_CNT;
        return s[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] decode32(input logic [4:0] v);
        return (v == 5'd0) ? FULL_CNT : CNT_W'(v);
    endfunction

    assign bits_n    = decode32(op_bits);
    assign pull_thr  = decode32(pull_thresh);
    assign push_thr  = decode32(push_thresh);
    assign shift_amt = bits_n;
    assign isr_sum   = sat_add(isr_count, bits_n);
    assign pull_due  = autopull && (osr_count >= pull_thr);
    // Reset also masks the strobes so an aborted op never touches a FIFO.
    assign active    = penable && !reset;

    always_comb begin
        state_nxt     = state;
        osr_count_nxt = osr_count;
        isr_count_nxt = isr_count;
        tx_pop        = 1'b0;
        rx_push       = 1'b0;
        osr_load      = 1'b0;
        osr_shift     = 1'b0;
        isr_shift     = 1'b0;
        isr_clear     = 1'b0;
        stall         = 1'b0;
        op_done       = 1'b0;
        if (active) begin
            unique case (state)
                IDLE: begin
                    if (!op_valid) begin
                        if (pull_due && !tx_empty) begin
                            tx_pop        = 1'b1;
                            osr_load      = 1'b1;
                            osr_count_nxt = '0;
                        end
                    end else begin
                        unique case (op_type)
                            OP_OUT: begin
                                if (pull_due) begin
                                    stall = 1'b1;
                                    if (!tx_empty) begin
                                        tx_pop        = 1'b1;
                                        osr_load      = 1'b1;
                                        osr_count_nxt = '0;
                                        state_nxt     = OUT_GO;
                                    end
                                end else begin
                                    osr_shift     = 1'b1;
                                    osr_count_nxt = sat_add(osr_count, bits_n);
                                    op_done       = 1'b1;
                                end
                            end
                            OP_IN: begin
                                isr_shift     = 1'b1;
                                isr_count_nxt = isr_sum;
                                if (autopush && (isr_sum >= push_thr)) begin
                                    stall     = 1'b1;
                                    state_nxt = IN_PUSH;
                                end else begin
                                    op_done = 1'b1;
                                end
                            end
                            OP_PULL: begin
                                if (!tx_empty) begin
                                    tx_pop        = 1'b1;
                                    osr_load      = 1'b1;
                                    osr_count_nxt = '0;
                                    op_done       = 1'b1;
                                end else if (op_block) begin
                                    stall = 1'b1;
                                end else begin
                                    op_done = 1'b1;
                                end
                            end
                            OP_PUSH: begin
                                if (!rx_full || !op_block) begin
                                    // A non-blocking push into a full FIFO drops the data.
                                    rx_push       = !rx_full;
                                    isr_clear     = 1'b1;
                                    isr_count_nxt = '0;
                                    op_done       = 1'b1;
                                end else begin
                                    stall = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                OUT_GO: begin
                    osr_shift     = 1'b1;
                    osr_count_nxt = sat_add(osr_count, bits_n);
                    op_done       = 1'b1;
                    state_nxt     = IDLE;
                end
                IN_PUSH: begin
                    if (rx_full) begin
                        stall = 1'b1;
                    end else begin
                        rx_push       = 1'b1;
                        isr_clear     = 1'b1;
                        isr_count_nxt = '0;
                        op_done       = 1'b1;
                        state_nxt     = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            osr_count <= CNT_W'(OSR_RST_CNT);
            isr_count <= '0;
        end else begin
            state     <= state_nxt;
            osr_count <= osr_count_nxt;
            isr_count <= isr_count_nxt;
        end
    end

endmodule

// File: tb/tb_shift_fifo_ctrl.sv
// Directed bench for shift_fifo_ctrl: each step drives inputs, checks the strobe
// vector mid-cycle, then checks the registered counts after the clock edge.
module tb_shift_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset, penable, op_valid, op_block, autopull, autopush, tx_empty, rx_full;
    logic [1:0] op_type;
    logic [4:0] op_bits, pull_thresh, push_thresh;
    logic       tx_pop, rx_push, osr_load, osr_shift, isr_shift, isr_clear, stall, op_done;
    logic [5:0] shift_amt, osr_count, isr_count;

    int total = 0;
    int bad   = 0;

    // Strobe vector order: {tx_pop,rx_push,osr_load,osr_shift,isr_shift,isr_clear,stall,op_done}
    localparam logic [7:0] S_NONE      = 8'b0000_0000;
    localparam logic [7:0] S_STALL     = 8'b0000_0010;
    localparam logic [7:0] S_DONE      = 8'b0000_0001;
    localparam logic [7:0] S_POPLD_STL = 8'b1010_0010;
    localparam logic [7:0] S_POPLD_DN  = 8'b1010_0001;
    localparam logic [7:0] S_OSH_DN    = 8'b0001_0001;
    localparam logic [7:0] S_ISH_DN    = 8'b0000_1001;
    localparam logic [7:0] S_ISH_STL   = 8'b0000_1010;
    localparam logic [7:0] S_PUSH_DN   = 8'b0100_0101;
    localparam logic [7:0] S_CLR_DN    = 8'b0000_0101;

    shift_fifo_ctrl dut (
        .clk(clk), .reset(reset), .penable(penable), .op_valid(op_valid),
        .op_type(op_type), .op_bits(op_bits), .op_block(op_block),
        .autopull(autopull), .autopush(autopush),
        .pull_thresh(pull_thresh), .push_thresh(push_thresh),
        .tx_empty(tx_empty), .rx_full(rx_full),
        .tx_pop(tx_pop), .rx_push(rx_push), .osr_load(osr_load),
        .osr_shift(osr_shift), .isr_shift(isr_shift), .isr_clear(isr_clear),
        .shift_amt(shift_amt), .osr_count(osr_count), .isr_count(isr_count),
        .stall(stall), .op_done(op_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs have been driven; let them settle and check the combinational strobes.
    task automatic strobes(input string tag, input logic [7:0] exp);
        #1;
        chk(tag, {tx_pop, rx_push, osr_load, osr_shift, isr_shift, isr_clear, stall, op_done}, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic v, input logic [1:0] t, input logic [4:0] b, input logic blk);
        op_valid = v;
        op_type  = t;
        op_bits  = b;
        op_block = blk;
    endtask

    initial begin
        reset = 1'b1; penable = 1'b1; autopull = 1'b1; autopush = 1'b0;
        pull_thresh = 5'd0; push_thresh = 5'd0; tx_empty = 1'b0; rx_full = 1'b0;
        op(1'b1, 2'd0, 5'd8, 1'b0);
        tick();

        // 1: reset state, then autopull refill on the first OUT.
        strobes("rst_strobes", S_NONE);
        chk("rst_state", dut.state, 0);
        chk("rst_osr", osr_count, 32);
        chk("rst_isr", isr_count, 0);
        reset = 1'b0;
        strobes("t1_pop", S_POPLD_STL);
        tick();
        chk("t1_osr0", osr_count, 0);
        strobes("t1_shift", S_OSH_DN);
        chk("t1_amt", shift_amt, 8);
        tick();
        chk("t1_osr8", osr_count, 8);

        // 2: drain the OSR, then stall on an empty TX FIFO.
        tx_empty = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            strobes("t2_out", S_OSH_DN);
            tick();
            chk("t2_osr", osr_count, 8 * i);
        end
        op(1'b0, 2'd0, 5'd8, 1'b0);
        strobes("t2_idle", S_NONE);
        tick();
        op(1'b1, 2'd0, 5'd8, 1'b0);
        for (int i = 0; i < 2; i++) begin
            strobes("t2_stall", S_STALL);
            tick();
            chk("t2_osr_hold", osr_count, 32);
        end
        tx_empty = 1'b0;
        strobes("t2_pop", S_POPLD_STL);
        tick();
        strobes("t2_shift", S_OSH_DN);
        tick();
        chk("t2_osr8", osr_count, 8);
        tx_empty = 1'b1;

        // 3: autopush at threshold 16 with RX full for three cycles.
        autopush = 1'b1; push_thresh = 5'd16;
        op(1'b1, 2'd1, 5'd8, 1'b0);
        strobes("t3_in1", S_ISH_DN);
        tick();
        chk("t3_isr8", isr_count, 8);
        rx_full = 1'b1;
        strobes("t3_in2", S_ISH_STL);
        tick();
        chk("t3_isr16", isr_count, 16);
        for (int i = 0; i < 3; i++) begin
            strobes("t3_full_stall", S_STALL);
            tick();
            chk("t3_isr_hold", isr_count, 16);
        end
        rx_full = 1'b0;
        strobes("t3_push", S_PUSH_DN);
        tick();
        chk("t3_isr0", isr_count, 0);

        // 4: non-blocking and blocking PULL/PUSH, plus IN count saturation.
        autopush = 1'b0;
        op(1'b1, 2'd2, 5'd0, 1'b0);
        strobes("t4_pull_nb", S_DONE);
        tick();
        chk("t4_osr_keep", osr_count, 8);
        op(1'b1, 2'd1, 5'd4, 1'b0);
        strobes("t4_in4", S_ISH_DN);
        tick();
        chk("t4_isr4", isr_count, 4);
        rx_full = 1'b1;
        op(1'b1, 2'd3, 5'd0, 1'b0);
        strobes("t4_push_nb", S_CLR_DN);
        tick();
        chk("t4_isr_drop", isr_count, 0);
        op(1'b1, 2'd3, 5'd0, 1'b1);
        strobes("t4_push_blk", S_STALL);
        tick();
        rx_full = 1'b0;
        strobes("t4_push_go", S_PUSH_DN);
        tick();
        op(1'b1, 2'd2, 5'd0, 1'b1);
        strobes("t4_pull_blk", S_STALL);
        tick();
        tx_empty = 1'b0;
        strobes("t4_pull_go", S_POPLD_DN);
        tick();
        chk("t4_osr_load", osr_count, 0);
        op(1'b1, 2'd1, 5'd0, 1'b0);
        strobes("t4_in32", S_ISH_DN);
        chk("t4_amt32", shift_amt, 32);
        tick();
        chk("t4_isr32", isr_count, 32);
        op(1'b1, 2'd1, 5'd8, 1'b0);
        strobes("t4_in_sat", S_ISH_DN);
        tick();
        chk("t4_isr_sat", isr_count, 32);

        // 5: OUT refill with penable pattern 0,1,0,1.
        tx_empty = 1'b1;
        op(1'b1, 2'd0, 5'd0, 1'b0);
        strobes("t5_out32", S_OSH_DN);
        tick();
        chk("t5_osr32", osr_count, 32);
        tx_empty = 1'b0;
        op(1'b1, 2'd0, 5'd8, 1'b0);
        penable = 1'b0;
        strobes("t5_pen0a", S_NONE);
        tick();
        chk("t5_osr_hold", osr_count, 32);
        penable = 1'b1;
        strobes("t5_pop", S_POPLD_STL);
        tick();
        penable = 1'b0;
        strobes("t5_pen0b", S_NONE);
        tick();
        chk("t5_state_hold", dut.state, 1);
        penable = 1'b1;
        strobes("t5_shift", S_OSH_DN);
        chk("t5_amt", shift_amt, 8);
        tick();
        chk("t5_osr8", osr_count, 8);

        // 6: reset while waiting in IN_PUSH with RX full.
        tx_empty = 1'b1; autopush = 1'b1; push_thresh = 5'd8; rx_full = 1'b1;
        op(1'b1, 2'd1, 5'd8, 1'b0);
        tick();
        chk("t6_state_push", dut.state, 2);
        strobes("t6_stall", S_STALL);
        reset = 1'b1;
        strobes("t6_rst_strobes", S_NONE);
        tick();
        reset = 1'b0; rx_full = 1'b0;
        op(1'b0, 2'd0, 5'd0, 1'b0);
        chk("t6_state_idle", dut.state, 0);
        chk("t6_isr0", isr_count, 0);
        strobes("t6_no_push", S_NONE);
        tick();
        strobes("t6_still_quiet", S_NONE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
